// File: rtl/fsm_password_lock_pkg.sv
// Shared types and widths for the keypad password lock.
package fsm_password_lock_pkg;

    localparam int PASS_W  = 16;
    localparam int DIGIT_W = 4;

    // Lock FSM states. The encoding is visible on curr_state, so keep these values fixed.
    typedef enum logic [2:0] {
        S_ENTRY = 3'd0,
        S_CHECK = 3'd1,
        S_UNLOCK = 3'd2,
        S_SET   = 3'd3,
        S_ALARM = 3'd4
    } state_t;

endpackage

// File: rtl/fsm_password_lock_key_edge.sv
// Rising-edge detector for the enter button.
// Produces one press per button push, however long the button is held.
module lock_key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic enter,
    output logic press
);

    logic enter_q;
    logic enter_d;

    // Next sample is simply the current button level.
    always_comb begin
        enter_d = enter;
        press   = enter & ~enter_q;
    end

    // Store the previous button level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) enter_q <= 1'b0;
        else        enter_q <= enter_d;
    end

endmodule

// File: rtl/fsm_password_lock.sv
// Four-digit keypad lock. It allows a bounded number of wrong tries, then raises
// a lockout alarm. When unlocked, the stored password can be viewed or changed.
module fsm_password_lock
    import fsm_password_lock_pkg::*;
#(
    parameter logic [15:0] DEFAULT_PASS = 16'h1234,
    parameter int          MAX_ATTEMPTS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  digit,
    input  logic        enter,
    input  logic        view_pass,
    input  logic        set_pass,
    output logic        green_led,
    output logic        red_led,
    output logic        alarm,
    output logic [15:0] viewed_pass,
    output logic [1:0]  attempts_left
);

    localparam logic [1:0] MAX_ATT = 2'(MAX_ATTEMPTS);

    state_t                curr_state, next_state;
    logic [1:0]            idx_q, idx_d;
    logic [PASS_W-1:0]     buf_q, buf_d;
    logic                  red_q, red_d;
    logic [1:0]            att_q, att_d;
    logic [PASS_W-1:0]     pass_d;
    // The password survives reset. Only the power-up value comes from the parameter.
    logic [PASS_W-1:0]     pass_q = DEFAULT_PASS;
    logic                  press;
    logic [PASS_W-1:0]     shifted;

    lock_key_edge u_key_edge (
        .clk   (clk),
        .rst_n (reset),
        .enter (enter),
        .press (press)
    );

    // Next-state logic, entry buffer update and attempt bookkeeping.
    always_comb begin
        next_state = curr_state;
        idx_d      = idx_q;
        buf_d      = buf_q;
        red_d      = red_q;
        att_d      = att_q;
        pass_d     = pass_q;
        shifted    = {buf_q[PASS_W-DIGIT_W-1:0], digit};
        case (curr_state)
            S_ENTRY: begin
                if (press) begin
                    buf_d = shifted;
                    idx_d = idx_q + 2'd1;
                    red_d = 1'b0;
                    if (idx_q == 2'd3) next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (buf_q == pass_q) begin
                    next_state = S_UNLOCK;
                    att_d      = MAX_ATT;
                    red_d      = 1'b0;
                end else begin
                    red_d = 1'b1;
                    att_d = att_q - 2'd1;
                    next_state = (att_q == 2'd1) ? S_ALARM : S_ENTRY;
                end
            end
            S_UNLOCK: begin
                // set_pass wins over a keypress in the same cycle; the keypress is dropped.
                if (set_pass) begin
                    next_state = S_SET;
                    idx_d      = 2'd0;
                end
            end
            S_SET: begin
                if (press) begin
                    buf_d = shifted;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        pass_d     = shifted;
                        att_d      = MAX_ATT;
                        next_state = S_ENTRY;
                    end
                end
            end
            S_ALARM: begin
                red_d = 1'b1;
                att_d = 2'd0;
            end
            default: next_state = S_ENTRY;
        endcase
    end

    // Control registers, cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            curr_state <= S_ENTRY;
            idx_q      <= 2'd0;
            buf_q      <= '0;
            red_q      <= 1'b0;
            att_q      <= MAX_ATT;
        end else begin
            curr_state <= next_state;
            idx_q      <= idx_d;
            buf_q      <= buf_d;
            red_q      <= red_d;
            att_q      <= att_d;
        end
    end

    // Password register. It has no reset, so a changed password persists.
    always_ff @(posedge clk) begin
        pass_q <= pass_d;
    end

    // Status outputs decoded from the state and registers.
    always_comb begin
        green_led     = (curr_state == S_UNLOCK) || (curr_state == S_SET);
        alarm         = (curr_state == S_ALARM);
        red_led       = red_q;
        attempts_left = att_q;
        viewed_pass   = (curr_state == S_UNLOCK && view_pass) ? pass_q : '0;
    end

endmodule

// File: tb/tb_fsm_password_lock.sv
// Directed bench for the password lock. Each step pushes its expected status
// into a scoreboard queue, then drains the queue against the DUT outputs.
module tb_fsm_password_lock;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  digit = 4'h0;
    logic        enter = 1'b0;
    logic        view_pass = 1'b0;
    logic        set_pass = 1'b0;
    logic        green_led, red_led, alarm;
    logic [15:0] viewed_pass;
    logic [1:0]  attempts_left;

    int total = 0;
    int bad = 0;

    typedef struct {
        string       tag;
        logic        g;
        logic        r;
        logic        a;
        logic [1:0]  att;
        logic [2:0]  st;
        logic [15:0] view;
    } exp_t;

    exp_t sb[$];

    fsm_password_lock dut (
        .clk           (clk),
        .reset         (reset),
        .digit         (digit),
        .enter         (enter),
        .view_pass     (view_pass),
        .set_pass      (set_pass),
        .green_led     (green_led),
        .red_led       (red_led),
        .alarm         (alarm),
        .viewed_pass   (viewed_pass),
        .attempts_left (attempts_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_st(input string tag, input logic g, input logic r, input logic a,
                             input logic [1:0] att, input logic [2:0] st, input logic [15:0] view);
        exp_t e;
        e.tag = tag; e.g = g; e.r = r; e.a = a; e.att = att; e.st = st; e.view = view;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".green"}, 32'(green_led), 32'(e.g));
            chk({e.tag, ".red"},   32'(red_led),   32'(e.r));
            chk({e.tag, ".alarm"}, 32'(alarm),     32'(e.a));
            chk({e.tag, ".att"},   32'(attempts_left), 32'(e.att));
            chk({e.tag, ".state"}, 32'(dut.curr_state), 32'(e.st));
            chk({e.tag, ".view"},  32'(viewed_pass), 32'(e.view));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b0;
        enter = 1'b0; set_pass = 1'b0; view_pass = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge clk); digit = d; enter = 1'b1;
        @(negedge clk); enter = 1'b0;
    endtask

    task automatic code(input logic [15:0] c);
        logic [15:0] v;
        v = c;
        press(v[15:12]); press(v[11:8]); press(v[7:4]); press(v[3:0]);
        idle(2);
    endtask

    initial begin
        // Reset state.
        idle(2);
        expect_st("reset", 0, 0, 0, 2'd3, 3'd0, 16'h0); drain();
        reset = 1'b1;
        idle(1);

        // Correct default password unlocks, and the password can be viewed.
        code(16'h1234);
        expect_st("unlock", 1, 0, 0, 2'd3, 3'd2, 16'h0); drain();
        view_pass = 1'b1; #1;
        expect_st("view_unlocked", 1, 0, 0, 2'd3, 3'd2, 16'h1234); drain();
        view_pass = 1'b0; #1;
        expect_st("view_off", 1, 0, 0, 2'd3, 3'd2, 16'h0); drain();

        // Viewing is blocked while locked.
        do_reset();
        view_pass = 1'b1; #1;
        expect_st("view_locked", 0, 0, 0, 2'd3, 3'd0, 16'h0); drain();
        view_pass = 1'b0;

        // Holding enter for 5 cycles captures exactly one digit.
        @(negedge clk); digit = 4'h1; enter = 1'b1;
        idle(5);
        enter = 1'b0;
        press(4'h2); press(4'h3); press(4'h4); idle(2);
        expect_st("hold_enter", 1, 0, 0, 2'd3, 3'd2, 16'h0); drain();

        // Reset mid-entry discards the partial digits.
        do_reset();
        press(4'h9); press(4'h9);
        do_reset();
        code(16'h1234);
        expect_st("partial_reset", 1, 0, 0, 2'd3, 3'd2, 16'h0); drain();

        // A wrong try, then a correct try. Red clears on the first new digit.
        do_reset();
        code(16'h5555);
        expect_st("wrong1", 0, 1, 0, 2'd2, 3'd0, 16'h0); drain();
        press(4'h1); idle(1);
        expect_st("red_clear", 0, 0, 0, 2'd2, 3'd0, 16'h0); drain();
        press(4'h2); press(4'h3); press(4'h4); idle(2);
        expect_st("recover", 1, 0, 0, 2'd3, 3'd2, 16'h0); drain();

        // Three wrong tries cause lockout. Input is ignored until reset.
        do_reset();
        code(16'h5555);
        expect_st("try1", 0, 1, 0, 2'd2, 3'd0, 16'h0); drain();
        code(16'h5555);
        expect_st("try2", 0, 1, 0, 2'd1, 3'd0, 16'h0); drain();
        code(16'h5555);
        expect_st("alarm", 0, 1, 1, 2'd0, 3'd4, 16'h0); drain();
        code(16'h1234);
        expect_st("alarm_hold", 0, 1, 1, 2'd0, 3'd4, 16'h0); drain();
        do_reset();
        expect_st("alarm_reset", 0, 0, 0, 2'd3, 3'd0, 16'h0); drain();

        // Password change. The keypress coinciding with set_pass must be dropped.
        code(16'h1234);
        @(negedge clk); set_pass = 1'b1; digit = 4'h9; enter = 1'b1;
        @(negedge clk); set_pass = 1'b0; enter = 1'b0;
        expect_st("set_mode", 1, 0, 0, 2'd3, 3'd3, 16'h0); drain();
        code(16'h9876);
        expect_st("set_done", 0, 0, 0, 2'd3, 3'd0, 16'h0); drain();
        do_reset();
        code(16'h9876);
        expect_st("new_pass", 1, 0, 0, 2'd3, 3'd2, 16'h0); drain();
        view_pass = 1'b1; #1;
        expect_st("view_new", 1, 0, 0, 2'd3, 3'd2, 16'h9876); drain();
        view_pass = 1'b0;
        do_reset();
        code(16'h1234);
        expect_st("old_pass", 0, 1, 0, 2'd2, 3'd0, 16'h0); drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
